// File: rtl/instr_decode_stage.sv
// LEGv8-subset decode stage: owns the 32 x XLEN register file and hands one registered bundle to execute.
// Optional feature macro: DECODE_WB_BYPASS_EN (writeback forwarding into captured and held operands).
module instr_decode_stage #(
   parameter int PC_W = 6,
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            clkreset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [PC_W-1:0] if_pc,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [PC_W-1:0] id_pc,
   output logic [2:0]      id_opclass,
   output logic [1:0]      id_alu_op,
   output logic [4:0]      id_rd,
   output logic [XLEN-1:0] id_rs1_data,
   output logic [XLEN-1:0] id_rs2_data,
   output logic [XLEN-1:0] id_imm,
   output logic            id_reg_write,
   output logic            id_illegal
);

   localparam logic [2:0] OC_ILLEGAL = 3'd0;
   localparam logic [2:0] OC_RALU    = 3'd1;
   localparam logic [2:0] OC_IALU    = 3'd2;
   localparam logic [2:0] OC_LOAD    = 3'd3;
   localparam logic [2:0] OC_STORE   = 3'd4;
   localparam logic [2:0] OC_CBZ     = 3'd5;
   localparam logic [2:0] OC_B       = 3'd6;

   logic [XLEN-1:0] r_regs [0:31];
   logic            r_valid;
   logic [PC_W-1:0] r_pc;
   logic [2:0]      r_opclass;
   logic [1:0]      r_alu_op;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic            r_reg_write;
   logic            r_illegal;
`ifdef DECODE_WB_BYPASS_EN
   logic [4:0]      r_rs1_idx;
   logic [4:0]      r_rs2_idx;
`endif

   logic            w_if_ready;
   logic            w_accept;
   logic [2:0]      w_opclass;
   logic [1:0]      w_alu_op;
   logic [XLEN-1:0] w_imm;
   logic            w_rs2_is_rt;
   logic            w_reg_write;
   logic            w_illegal;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1_idx;
   logic [4:0]      w_rs2_idx;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   assign w_if_ready = !r_valid || id_ready;
   assign w_accept   = if_valid && w_if_ready;
   assign if_ready   = w_if_ready;

   // Opcode classification and immediate extraction; the opcode patterns are mutually disjoint.
   always_comb begin
      w_opclass   = OC_ILLEGAL;
      w_alu_op    = 2'b00;
      w_imm       = {XLEN{1'b0}};
      w_rs2_is_rt = 1'b0;
      if (if_instr[31:21] == 11'b10001011000) begin
         w_opclass = OC_RALU;
      end else if (if_instr[31:21] == 11'b11001011000) begin
         w_opclass = OC_RALU;
         w_alu_op  = 2'b01;
      end else if (if_instr[31:21] == 11'b10001010000) begin
         w_opclass = OC_RALU;
         w_alu_op  = 2'b10;
      end else if (if_instr[31:21] == 11'b10101010000) begin
         w_opclass = OC_RALU;
         w_alu_op  = 2'b11;
      end else if (if_instr[31:22] == 10'b1001000100) begin
         w_opclass = OC_IALU;
         w_imm     = {{(XLEN-12){1'b0}}, if_instr[21:10]};
      end else if (if_instr[31:22] == 10'b1101000100) begin
         w_opclass = OC_IALU;
         w_alu_op  = 2'b01;
         w_imm     = {{(XLEN-12){1'b0}}, if_instr[21:10]};
      end else if (if_instr[31:21] == 11'b11111000010) begin
         w_opclass = OC_LOAD;
         w_imm     = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
      end else if (if_instr[31:21] == 11'b11111000000) begin
         w_opclass   = OC_STORE;
         w_imm       = {{(XLEN-9){if_instr[20]}}, if_instr[20:12]};
         w_rs2_is_rt = 1'b1;
      end else if (if_instr[31:24] == 8'b10110100) begin
         w_opclass   = OC_CBZ;
         w_imm       = {{(XLEN-19){if_instr[23]}}, if_instr[23:5]};
         w_rs2_is_rt = 1'b1;
      end else if (if_instr[31:26] == 6'b000101) begin
         w_opclass = OC_B;
         w_imm     = {{(XLEN-26){if_instr[25]}}, if_instr[25:0]};
      end else begin
         w_opclass = OC_ILLEGAL;
      end
   end

   assign w_illegal   = (w_opclass == OC_ILLEGAL);
   assign w_reg_write = (w_opclass == OC_RALU) || (w_opclass == OC_IALU) || (w_opclass == OC_LOAD);
   assign w_rd        = w_reg_write ? if_instr[4:0] : 5'd0;
   assign w_rs1_idx   = if_instr[9:5];
   assign w_rs2_idx   = w_rs2_is_rt ? if_instr[4:0] : if_instr[20:16];

   // Operand read port; X31 is hardwired to zero.
   always_comb begin
      w_rs1_data = (w_rs1_idx == 5'd31) ? {XLEN{1'b0}} : r_regs[w_rs1_idx];
      w_rs2_data = (w_rs2_idx == 5'd31) ? {XLEN{1'b0}} : r_regs[w_rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && (wb_rd == w_rs1_idx) && (w_rs1_idx != 5'd31)) begin
         w_rs1_data = wb_data;
      end else begin
         w_rs1_data = w_rs1_data;
      end
      if (wb_en && (wb_rd == w_rs2_idx) && (w_rs2_idx != 5'd31)) begin
         w_rs2_data = wb_data;
      end else begin
         w_rs2_data = w_rs2_data;
      end
`endif
   end

   // Register file write port.
   always_ff @(posedge clk) begin
      if (clkreset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= {XLEN{1'b0}};
         end
      end else if (wb_en && (wb_rd != 5'd31)) begin
         r_regs[wb_rd] <= wb_data;
      end
   end

   // Decode bundle register: flush wins over capture, stall holds the bundle.
   always_ff @(posedge clk) begin
      if (clkreset) begin
         r_valid     <= 1'b0;
         r_pc        <= {PC_W{1'b0}};
         r_opclass   <= 3'd0;
         r_alu_op    <= 2'b00;
         r_rd        <= 5'd0;
         r_rs1_data  <= {XLEN{1'b0}};
         r_rs2_data  <= {XLEN{1'b0}};
         r_imm       <= {XLEN{1'b0}};
         r_reg_write <= 1'b0;
         r_illegal   <= 1'b0;
`ifdef DECODE_WB_BYPASS_EN
         r_rs1_idx   <= 5'd0;
         r_rs2_idx   <= 5'd0;
`endif
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid     <= 1'b1;
         r_pc        <= if_pc;
         r_opclass   <= w_opclass;
         r_alu_op    <= w_alu_op;
         r_rd        <= w_rd;
         r_rs1_data  <= w_rs1_data;
         r_rs2_data  <= w_rs2_data;
         r_imm       <= w_imm;
         r_reg_write <= w_reg_write;
         r_illegal   <= w_illegal;
`ifdef DECODE_WB_BYPASS_EN
         r_rs1_idx   <= w_rs1_idx;
         r_rs2_idx   <= w_rs2_idx;
`endif
      end else if (id_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
`ifdef DECODE_WB_BYPASS_EN
         // Held operands follow writes to their source registers while execute is stalled.
         if (wb_en && (wb_rd == r_rs1_idx) && (r_rs1_idx != 5'd31)) begin
            r_rs1_data <= wb_data;
         end
         if (wb_en && (wb_rd == r_rs2_idx) && (r_rs2_idx != 5'd31)) begin
            r_rs2_data <= wb_data;
         end
`endif
      end
   end

   assign id_valid     = r_valid;
   assign id_pc        = r_pc;
   assign id_opclass   = r_opclass;
   assign id_alu_op    = r_alu_op;
   assign id_rd        = r_rd;
   assign id_rs1_data  = r_rs1_data;
   assign id_rs2_data  = r_rs2_data;
   assign id_imm       = r_imm;
   assign id_reg_write = r_reg_write;
   assign id_illegal   = r_illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed decode table, hand-written stall/flush/reset sequences,
// then random traffic checked every cycle against an instruction-level reference model.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        clkreset, if_valid, if_ready, flush, wb_en, id_valid, id_ready;
   logic [31:0] if_instr;
   logic [5:0]  if_pc, id_pc;
   logic [4:0]  wb_rd, id_rd;
   logic [63:0] wb_data, id_rs1_data, id_rs2_data, id_imm;
   logic [2:0]  id_opclass;
   logic [1:0]  id_alu_op;
   logic        id_reg_write, id_illegal;

   instr_decode_stage #(.PC_W(6), .XLEN(64)) dut (
      .clk(clk), .clkreset(clkreset), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_opclass(id_opclass), .id_alu_op(id_alu_op), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_illegal(id_illegal));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [5:0]  pc;
      logic [2:0]  oc;
      logic [1:0]  alu;
      logic [4:0]  rd;
      logic [63:0] rs1, rs2, imm;
      logic        rw, ill;
      int          s1, s2;
   } mb_t;

   logic [63:0] m_regs [32];
   logic        m_valid;
   mb_t         m_b;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sext(longint v, int n);
      longint s = v;
      if (s >= (longint'(1) << (n - 1))) s = s - (longint'(1) << n);
      return s;
   endfunction

   function automatic logic [63:0] oper(int idx);
      if (idx == 31) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && int'(wb_rd) == idx) return wb_data;
`endif
      return m_regs[idx];
   endfunction

   // Reference decode straight from the instruction-set rules.
   function automatic mb_t ref_decode(logic [31:0] ins, logic [5:0] pc);
      mb_t b;
      longint u  = longint'(ins);
      int op11   = int'(u >> 21);
      int op10   = int'(u >> 22);
      int rd_f   = int'(u % 32);
      int rn_f   = int'((u >> 5) % 32);
      int rm_f   = int'((u >> 16) % 32);
      b.pc = pc; b.alu = 2'd0; b.imm = 64'd0; b.oc = 3'd0; b.s2 = rm_f;
      if      (op11 == 'h458) b.oc = 3'd1;
      else if (op11 == 'h658) begin b.oc = 3'd1; b.alu = 2'd1; end
      else if (op11 == 'h450) begin b.oc = 3'd1; b.alu = 2'd2; end
      else if (op11 == 'h550) begin b.oc = 3'd1; b.alu = 2'd3; end
      else if (op10 == 'h244 || op10 == 'h344) begin
         b.oc = 3'd2; b.alu = (op10 == 'h344) ? 2'd1 : 2'd0; b.imm = (u >> 10) % 4096;
      end else if (op11 == 'h7C2 || op11 == 'h7C0) begin
         b.oc = (op11 == 'h7C2) ? 3'd3 : 3'd4; b.imm = sext((u >> 12) % 512, 9);
         if (op11 == 'h7C0) b.s2 = rd_f;
      end else if ((u >> 24) == 'hB4) begin
         b.oc = 3'd5; b.imm = sext((u >> 5) % (1 << 19), 19); b.s2 = rd_f;
      end else if ((u >> 26) == 5) begin
         b.oc = 3'd6; b.imm = sext(u % (1 << 26), 26);
      end
      b.ill = (b.oc == 3'd0);
      b.rw  = (b.oc == 3'd1 || b.oc == 3'd2 || b.oc == 3'd3);
      b.rd  = b.rw ? 5'(rd_f) : 5'd0;
      b.s1  = rn_f;
      b.rs1 = oper(rn_f);
      b.rs2 = oper(b.s2);
      return b;
   endfunction

   // One clock: model next state from current inputs, clock, then compare against the model.
   task automatic tick();
      mb_t nb;
      logic nv;
      #1;
      chk("if_ready", if_ready, (!m_valid || id_ready));
      nb = m_b; nv = m_valid;
      if (clkreset) begin
         nv = 1'b0; nb = '{default: '0};
      end else if (flush) nv = 1'b0;
      else if (if_valid && (!m_valid || id_ready)) begin nv = 1'b1; nb = ref_decode(if_instr, if_pc); end
      else if (id_ready) nv = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
      else if (wb_en && wb_rd != 5'd31) begin
         if (int'(wb_rd) == m_b.s1) nb.rs1 = wb_data;
         if (int'(wb_rd) == m_b.s2) nb.rs2 = wb_data;
      end
`endif
      @(posedge clk);
      if (clkreset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      end else if (wb_en && wb_rd != 5'd31) m_regs[wb_rd] = wb_data;
      m_valid = nv; m_b = nb;
      #1;
      chk("model_valid", id_valid, m_valid);
      if (m_valid) begin
         chk("model_pc", id_pc, m_b.pc);
         chk("model_opclass", id_opclass, m_b.oc);
         chk("model_alu_op", id_alu_op, m_b.alu);
         chk("model_rd", id_rd, m_b.rd);
         chk("model_rs1", id_rs1_data, m_b.rs1);
         if (m_b.oc == 3'd1 || m_b.oc == 3'd4 || m_b.oc == 3'd5) chk("model_rs2", id_rs2_data, m_b.rs2);
         chk("model_imm", id_imm, m_b.imm);
         chk("model_reg_write", id_reg_write, m_b.rw);
         chk("model_illegal", id_illegal, m_b.ill);
      end
   endtask

   task automatic idle();
      if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; id_ready = 1'b1; clkreset = 1'b0;
   endtask

   task automatic wr(logic [4:0] rd, logic [63:0] d);
      idle(); wb_en = 1'b1; wb_rd = rd; wb_data = d; tick(); wb_en = 1'b0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_valid"}, id_valid, 64'd0);
      chk({tag, "_fields"}, {id_pc, id_opclass, id_alu_op, id_rd, id_reg_write, id_illegal}, 64'd0);
      chk({tag, "_rs1"}, id_rs1_data, 64'd0);
      chk({tag, "_rs2"}, id_rs2_data, 64'd0);
      chk({tag, "_imm"}, id_imm, 64'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      if ($urandom_range(0, 3) != 0) begin r[9:8] = 2'b00; r[20:19] = 2'b00; r[4:3] = 2'b00; end
      case ($urandom_range(0, 10))
         0: r[31:21] = 11'h458;
         1: r[31:21] = 11'h658;
         2: r[31:21] = 11'h450;
         3: r[31:21] = 11'h550;
         4: r[31:22] = 10'h244;
         5: r[31:22] = 10'h344;
         6: r[31:21] = 11'h7C2;
         7: r[31:21] = 11'h7C0;
         8: r[31:24] = 8'hB4;
         9: r[31:26] = 6'h05;
         default: r = r;
      endcase
      return r;
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  oc;
      logic [1:0]  alu;
      logic [4:0]  rd;
      logic [63:0] rs1, rs2;
      logic        chk_rs2;
      logic [63:0] imm;
      logic        rw, ill;
   } vec_t;

   vec_t tbl [12];
   logic [63:0] exp_rs1;

   initial begin
      tbl[0]  = '{32'h8B020023, 3'd1, 2'd0, 5'd3,  64'd5,  64'd7,  1'b1, 64'd0, 1'b1, 1'b0};
      tbl[1]  = '{32'h910193E5, 3'd2, 2'd0, 5'd5,  64'd0,  64'd0,  1'b0, 64'd100, 1'b1, 1'b0};
      tbl[2]  = '{32'hF85F8047, 3'd3, 2'd0, 5'd7,  64'd7,  64'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0};
      tbl[3]  = '{32'hB4FFFFC4, 3'd5, 2'd0, 5'd0,  64'd0,  64'd11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      tbl[4]  = '{32'hFFFFFFFF, 3'd0, 2'd0, 5'd0,  64'd0,  64'd0,  1'b0, 64'd0, 1'b0, 1'b1};
      tbl[5]  = '{32'hCB010046, 3'd1, 2'd1, 5'd6,  64'd7,  64'd5,  1'b1, 64'd0, 1'b1, 1'b0};
      tbl[6]  = '{32'h8A040028, 3'd1, 2'd2, 5'd8,  64'd5,  64'd11, 1'b1, 64'd0, 1'b1, 1'b0};
      tbl[7]  = '{32'hAA020089, 3'd1, 2'd3, 5'd9,  64'd11, 64'd7,  1'b1, 64'd0, 1'b1, 1'b0};
      tbl[8]  = '{32'hD13FFC2A, 3'd2, 2'd1, 5'd10, 64'd5,  64'd0,  1'b0, 64'd4095, 1'b1, 1'b0};
      tbl[9]  = '{32'hF80FF024, 3'd4, 2'd0, 5'd0,  64'd5,  64'd11, 1'b1, 64'd255, 1'b0, 1'b0};
      tbl[10] = '{32'h17FFFFFF, 3'd6, 2'd0, 5'd0,  64'd0,  64'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      tbl[11] = '{32'h14000001, 3'd6, 2'd0, 5'd0,  64'd0,  64'd0,  1'b0, 64'd1, 1'b0, 1'b0};

      m_valid = 1'b0; m_b = '{default: '0};
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      if_instr = 32'd0; if_pc = 6'd0; wb_rd = 5'd0; wb_data = 64'd0;
      idle(); clkreset = 1'b1;
      tick(); tick();
      chk_all_zero("reset");
      clkreset = 1'b0;

      wr(5'd1, 64'd5); wr(5'd2, 64'd7); wr(5'd4, 64'd11);

      // Directed decode table, back-to-back with execute always ready.
      for (int i = 0; i < 12; i++) begin
         idle(); if_valid = 1'b1; if_instr = tbl[i].ins; if_pc = 6'(i);
         tick();
         chk($sformatf("tbl%0d_valid", i), id_valid, 64'd1);
         chk($sformatf("tbl%0d_pc", i), id_pc, 64'(i));
         chk($sformatf("tbl%0d_opclass", i), id_opclass, tbl[i].oc);
         chk($sformatf("tbl%0d_alu_op", i), id_alu_op, tbl[i].alu);
         chk($sformatf("tbl%0d_rd", i), id_rd, tbl[i].rd);
         chk($sformatf("tbl%0d_rs1", i), id_rs1_data, tbl[i].rs1);
         if (tbl[i].chk_rs2) chk($sformatf("tbl%0d_rs2", i), id_rs2_data, tbl[i].rs2);
         chk($sformatf("tbl%0d_imm", i), id_imm, tbl[i].imm);
         chk($sformatf("tbl%0d_reg_write", i), id_reg_write, tbl[i].rw);
         chk($sformatf("tbl%0d_illegal", i), id_illegal, tbl[i].ill);
      end

      // Stall for 3 cycles with fetch still offering; X1 rewritten during the stall.
      idle(); if_valid = 1'b1; if_instr = 32'h8B020023; if_pc = 6'd20; tick();
      id_ready = 1'b0; if_instr = 32'hCB010046; if_pc = 6'd21;
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd9;
      tick();
      wb_en = 1'b0;
      chk("stall_if_ready", if_ready, 64'd0);
      tick(); tick();
`ifdef DECODE_WB_BYPASS_EN
      exp_rs1 = 64'd9;
`else
      exp_rs1 = 64'd5;
`endif
      chk("stall_valid", id_valid, 64'd1);
      chk("stall_pc", id_pc, 64'd20);
      chk("stall_rd", id_rd, 64'd3);
      chk("stall_rs2", id_rs2_data, 64'd7);
      chk("stall_rs1_refresh", id_rs1_data, exp_rs1);
      id_ready = 1'b1; tick();
      chk("after_stall_pc", id_pc, 64'd21);
      chk("after_stall_rs2", id_rs2_data, 64'd9);
      wr(5'd1, 64'd5);

      // Flush beats a same-cycle accept.
      idle(); if_valid = 1'b1; if_instr = 32'h8B020023; flush = 1'b1; tick();
      chk("flush_valid", id_valid, 64'd0);

      // Writes to X31 are dropped.
      wr(5'd31, 64'hDEAD_BEEF_0000_1234);
      idle(); if_valid = 1'b1; if_instr = 32'h8B1F03E3; if_pc = 6'd33; tick();
      chk("x31_rs1", id_rs1_data, 64'd0);
      chk("x31_rs2", id_rs2_data, 64'd0);

      // Reset during a stall drops the bundle and clears the register file.
      idle(); if_valid = 1'b1; if_instr = 32'h8B020023; tick();
      id_ready = 1'b0; tick();
      clkreset = 1'b1; tick();
      chk_all_zero("reset_stall");
      idle(); if_valid = 1'b1; if_instr = 32'h8B020023; if_pc = 6'd7; tick();
      chk("post_reset_rs1", id_rs1_data, 64'd0);
      chk("post_reset_rs2", id_rs2_data, 64'd0);

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         if_valid = ($urandom_range(0, 3) != 0);
         if_instr = rand_instr();
         if_pc    = 6'($urandom);
         id_ready = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 15) == 0);
         wb_en    = ($urandom_range(0, 1) == 1);
         wb_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wb_data  = {$urandom, $urandom};
         clkreset = ($urandom_range(0, 499) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
